// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end.
//
// Contents:
//   CPU_XLEN        default datapath width (PC and instruction words)
//   CPU_PC_STEP     default sequential PC increment in bytes
//   CPU_RESET_PC    default first fetch address after reset
//   CPU_FETCH_DEPTH default prefetch FIFO depth
//   fetch_entry_t   one prefetched instruction {pc, inst} at default width
package cpu_pkg;

    localparam int CPU_XLEN        = 32;
    localparam int CPU_PC_STEP     = 4;
    localparam int CPU_FETCH_DEPTH = 4;
    localparam logic [CPU_XLEN-1:0] CPU_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding prefetched instructions until decode pulls them.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (pointers, count, primed flag)
//   flush      empties the queue at the end of this cycle; wins over push/pop
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        advance the head
//   head       entry at the read pointer (stale when the queue is empty)
//   count      current occupancy, 0..DEPTH
//   primed     set by the first push after reset; head is undefined until then
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             primed
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // NOTE: the storage array is deliberately left out of reset; consumers
    // gate the head with 'primed', so clearing every entry would buy nothing.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            primed <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                primed <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-cycle-latency instruction
// memory request port and a prefetch FIFO toward decode. Redirects from
// later stages flush the queue and drop the read that is in flight.
//
// Ports:
//   clk          system clock
//   pcrst        synchronous active-high reset
//   imem_req     read request this cycle
//   imem_addr    read address (valid with imem_req)
//   imem_rdata   read data, valid the cycle after an accepted request
//   dec_valid    queue head valid toward decode
//   dec_ready    decode accepts the head
//   dec_inst     head instruction
//   dec_pc       head PC
//   dec_npc      head PC + PC_STEP
//   redir_valid  redirect request from execute
//   redir_pc     redirect target
//   q_count      current queue occupancy
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int XLEN  = CPU_XLEN,
    parameter int DEPTH = CPU_FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = CPU_RESET_PC,
    parameter int PC_STEP = CPU_PC_STEP,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            pcrst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_inst,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_npc,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic [CW-1:0]   q_count
);

    // Same layout as cpu_pkg::fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;

    logic            push;
    logic            pop;
    logic [CW:0]     occupancy;
    entry_t          push_entry;
    entry_t          head_entry;
    entry_t          head_raw;
    logic [CW-1:0]   count;
    logic            primed;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_valid = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        occupancy = '0;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;

        // A redirect cycle hides the head and drops the arriving response.
        dec_valid = (count != '0) && !redir_valid;
        pop       = dec_valid && dec_ready;
        push      = inflight && !redir_valid;

        // Entries held plus the one landing next cycle, less the one leaving
        // now; a request is only issued if that data is sure to have a slot.
        occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        imem_req  = !pcrst && (redir_valid || (occupancy < (CW+1)'(DEPTH)));
        imem_addr = redir_valid ? redir_pc : fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (pcrst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (imem_req) begin
            inflight    <= 1'b1;
            inflight_pc <= imem_addr;
            fetch_pc    <= imem_addr + XLEN'(PC_STEP);
        end else begin
            inflight    <= 1'b0;
        end
    end

    assign push_entry = '{pc: inflight_pc, inst: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (pcrst),
        .flush     (redir_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_raw),
        .count     (count),
        .primed    (primed)
    );

    // Until the first entry lands after reset the head reads as all zeros.
    assign head_entry = primed ? head_raw : '0;

    assign dec_pc   = head_entry.pc;
    assign dec_inst = head_entry.inst;
    assign dec_npc  = primed ? head_entry.pc + XLEN'(PC_STEP) : '0;
    assign q_count  = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, PC_STEP=4, RESET_PC=0).
// The memory model returns addr ^ 32'hA5A5_0000 one cycle after a request.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        pcrst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [31:0] dec_npc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .pcrst       (pcrst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_npc     (dec_npc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory with one-cycle latency.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The queue must never hold more than DEPTH entries.
    always @(negedge clk) begin
        check("q_count_bound", 32'(q_count <= 3'(DEPTH)), 32'd1);
    end

    initial begin
        int transfers;
        logic [31:0] exp_pc;

        pcrst       = 1'b1;
        dec_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        tick();
        tick();
        #1;
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_q_count",   32'(q_count),   32'd0);
        check("rst_imem_req",  32'(imem_req),  32'd0);
        check("rst_dec_pc",    dec_pc,         32'h0);
        check("rst_dec_npc",   dec_npc,        32'h0);
        check("rst_dec_inst",  dec_inst,       32'h0);

        // Streaming with decode always ready: cycle 0 requests RESET_PC.
        pcrst     = 1'b0;
        dec_ready = 1'b1;
        #1;
        check("c0_imem_req",  32'(imem_req), 32'd1);
        check("c0_imem_addr", imem_addr,     32'h0);
        tick();
        check("c1_dec_valid", 32'(dec_valid), 32'd0);
        check("c1_q_count",   32'(q_count),   32'd0);
        for (int n = 2; n < 8; n++) begin
            tick();
            check("stream_valid", 32'(dec_valid), 32'd1);
            check("stream_pc",    dec_pc,         32'(4 * (n - 2)));
            check("stream_npc",   dec_npc,        32'(4 * (n - 2) + 4));
            check("stream_inst",  dec_inst,       32'(4 * (n - 2)) ^ KEY);
            check("stream_count", 32'(q_count),   32'd1);
        end

        // Fill the queue with decode stalled from cycle 0.
        tick();
        pcrst     = 1'b1;
        dec_ready = 1'b0;
        #1;
        check("rst2_imem_req", 32'(imem_req), 32'd0);
        tick();
        pcrst = 1'b0;
        #1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            check("fill_req",   32'(imem_req), (c < 4) ? 32'd1 : 32'd0);
            check("fill_addr",  imem_addr,     (c < 4) ? 32'(4 * c) : 32'd16);
            check("fill_count", 32'(q_count),  (c < 2) ? 32'd0 : ((c - 1 > 4) ? 32'd4 : 32'(c - 1)));
        end
        tick();
        dec_ready = 1'b1;
        #1;
        check("drain_valid", 32'(dec_valid), 32'd1);
        check("drain_pc0",   dec_pc,         32'h0);
        check("drain_req",   32'(imem_req),  32'd1);
        check("drain_addr",  imem_addr,      32'd16);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("drain_pc",   dec_pc,   32'(4 * i));
            check("drain_inst", dec_inst, 32'(4 * i) ^ KEY);
        end

        // Redirect with three queued entries, a read in flight and a handshake.
        tick();
        check("redir_pre_count", 32'(q_count), 32'd3);
        redir_valid = 1'b1;
        redir_pc    = 32'h100;
        #1;
        check("redir_dec_valid", 32'(dec_valid), 32'd0);
        check("redir_req",       32'(imem_req),  32'd1);
        check("redir_addr",      imem_addr,      32'h100);
        tick();
        redir_valid = 1'b0;
        #1;
        check("redir_flushed",   32'(q_count),   32'd0);
        check("redir_t1_valid",  32'(dec_valid), 32'd0);
        check("redir_t1_addr",   imem_addr,      32'h104);
        tick();
        check("redir_t2_valid",  32'(dec_valid), 32'd1);
        check("redir_t2_pc",     dec_pc,         32'h100);
        check("redir_t2_inst",   dec_inst,       32'h100 ^ KEY);
        check("redir_t2_count",  32'(q_count),   32'd1);
        tick();
        check("redir_t3_pc",     dec_pc,         32'h104);

        // Back-to-back redirects: only the latest target survives.
        redir_valid = 1'b1;
        redir_pc    = 32'h200;
        #1;
        check("b2b_valid0", 32'(dec_valid), 32'd0);
        tick();
        redir_pc = 32'h300;
        #1;
        check("b2b_valid1", 32'(dec_valid), 32'd0);
        check("b2b_addr",   imem_addr,      32'h300);
        tick();
        redir_valid = 1'b0;
        #1;
        check("b2b_count",  32'(q_count),   32'd0);
        tick();
        check("b2b_valid",  32'(dec_valid), 32'd1);
        check("b2b_pc",     dec_pc,         32'h300);
        tick();
        check("b2b_pc_next", dec_pc,        32'h304);
        check("b2b_count1",  32'(q_count),  32'd1);
        dec_ready = 1'b0;
        #1;

        // Reset in the middle of a stream with two entries queued.
        tick();
        check("mid_count", 32'(q_count), 32'd2);
        check("mid_head",  dec_pc,       32'h304);
        pcrst = 1'b1;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        tick();
        check("mid_rst_count", 32'(q_count),   32'd0);
        check("mid_rst_valid", 32'(dec_valid), 32'd0);
        check("mid_rst_req2",  32'(imem_req),  32'd0);
        check("mid_rst_pc",    dec_pc,         32'h0);
        pcrst     = 1'b0;
        dec_ready = 1'b1;
        #1;
        check("restart_req",  32'(imem_req), 32'd1);
        check("restart_addr", imem_addr,     32'h0);
        tick();
        tick();
        check("restart_valid", 32'(dec_valid), 32'd1);
        check("restart_pc",    dec_pc,         32'h0);

        // Random decode stalls across pointer wrap: PCs must stay contiguous.
        exp_pc    = 32'd4;
        transfers = 0;
        for (int cyc = 0; cyc < 200 && transfers < 3 * DEPTH + 1; cyc++) begin
            tick();
            dec_ready = 1'($urandom_range(0, 1));
            #1;
            if (dec_valid && dec_ready) begin
                check("rand_pc",   dec_pc,   exp_pc);
                check("rand_inst", dec_inst, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                transfers++;
            end
        end
        check("rand_transfers", 32'(transfers), 32'(3 * DEPTH + 1));

        // Redirect to the top of the address space: the PC wraps to 0.
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFFC;
        dec_ready   = 1'b1;
        #1;
        check("wrap_redir_valid", 32'(dec_valid), 32'd0);
        tick();
        redir_valid = 1'b0;
        #1;
        tick();
        check("wrap_valid", 32'(dec_valid), 32'd1);
        check("wrap_pc",    dec_pc,         32'hFFFF_FFFC);
        check("wrap_npc",   dec_npc,        32'h0);
        check("wrap_inst",  dec_inst,       32'hFFFF_FFFC ^ KEY);
        tick();
        check("wrap_next_pc",   dec_pc,   32'h0);
        check("wrap_next_inst", dec_inst, KEY);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined CPU.
- Replaces the single PC register and IF/ID latch pair with three parts:
  - a PC generator;
  - a synchronous instruction-memory request port with one-cycle read latency;
  - a DEPTH-entry prefetch FIFO.
- Decode pulls {pc, npc, inst} with a valid/ready handshake, so a decode stall no longer freezes fetch.
- Later stages redirect fetch on a taken branch or jump. A redirect flushes the queue and discards the in-flight read.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- pcrst  in  1  synchronous reset, active-high.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  read address; valid when imem_req=1.
- imem_rdata  in  XLEN  read data; valid the cycle after an accepted request.
- dec_valid  out  1  FIFO head valid toward decode.
- dec_ready  in  1  decode accepts the head (inverse of the decode stall).
- dec_inst  out  XLEN  head instruction.
- dec_pc  out  XLEN  head PC.
- dec_npc  out  XLEN  head PC + PC_STEP (feeds branch-target adders).
- redir_valid  in  1  redirect request from execute.
- redir_pc  in  XLEN  redirect target.
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Reset has priority over every other event.
  - At the reset edge: fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0, inflight=0, inflight_pc=0.
  - During reset and after it, while count=0: dec_valid=0, q_count=0. dec_inst/dec_pc/dec_npc read as 0.
  - imem_req=0 while pcrst=1.
- Issue rule:
  - pop = dec_valid & dec_ready & ~redir_valid.
  - imem_req = ~pcrst & (redir_valid | (count + inflight - pop < DEPTH)).
  - imem_addr = redir_valid ? redir_pc : fetch_pc (combinational).
- On an issued request:
  - inflight<=1, inflight_pc<=imem_addr.
  - fetch_pc<=imem_addr+PC_STEP, modulo 2^XLEN (wraps silently).
- With no request issued, inflight<=0.
- Response:
  - When inflight=1 and the cycle is not a redirect cycle, {inflight_pc, imem_rdata} is written at wr_ptr.
  - wr_ptr then increments modulo DEPTH.
- Pop:
  - When pop=1, rd_ptr increments modulo DEPTH.
  - dec_* always show the entry at rd_ptr.
  - dec_npc = dec_pc + PC_STEP.
- Count:
  - count <= count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - The issue rule guarantees no push when count=DEPTH without a pop. An overflow is a design error; the bench asserts it never occurs.
- Redirect in cycle t:
  - Queue flushed at the end of t (pointers and count to 0).
  - Any response arriving in t is dropped.
  - dec_valid is forced 0 in t; a handshake in t is not a pop.
  - A request for redir_pc is issued in t. Its data arrives in t+1, and dec_valid=1 with dec_pc=redir_pc in t+2.
  - A redirect in back-to-back cycles keeps only the latest target.
- Latency: reset deasserts before cycle 0. Request for RESET_PC in cycle 0, data in cycle 1, dec_valid in cycle 2.
- Throughput: one instruction per cycle sustained whenever dec_ready=1 and DEPTH>=2.
- Empty: dec_valid=0 and dec_* hold the stale entry at rd_ptr; decode must qualify with dec_valid.
- Full: count=DEPTH and dec_ready=0 gives imem_req=0. fetch_pc holds.
- Memory: imem_rdata is sampled only in the cycle after a request; unused cycles are ignored.

Decomposition:
- Shared package (cpu_pkg) holds:
  - XLEN and PC_STEP defaults;
  - RESET_PC;
  - a fetch-entry struct or typedef {pc, inst}.
- One sub-module: fetch_fifo.
  - Parametrised DEPTH/width circular buffer with push, pop, flush, count and head outputs.
  - PC generation, the issue rule and redirect handling stay in fetch_queue.

Test Plan:
- Reset then dec_ready=1, imem_rdata=addr^32'hA5A5_0000 → dec_valid from cycle 2 with dec_pc 0,4,8,… one per cycle. dec_npc=dec_pc+4. q_count≤2.
- Hold dec_ready=0 from cycle 0 with DEPTH=4 → q_count reaches 4. imem_req low from the cycle count+inflight hits 4. fetch_pc holds at 16. Releasing dec_ready drains PCs 0,4,8,12 then 16.
- Redirect to 32'h100 while q_count=3 with a read in flight:
  - in the redirect cycle: dec_valid=0 and imem_addr=0x100;
  - next cycle: q_count=0;
  - two cycles later: dec_pc=0x100, then 0x104. No stale PC ever appears.
- Redirect in the same cycle as dec_valid=dec_ready=1 → no pop is counted, the queue is flushed, and the next valid is redir_pc.
- Assert pcrst mid-stream with q_count=2 → next cycle q_count=0, dec_valid=0, imem_req=0. After release, fetch restarts at RESET_PC.
- Run 3×DEPTH+1 transfers with random dec_ready → pointers wrap and the PC sequence is contiguous. Also redirect to 32'hFFFF_FFFC: the next sequential PC is 0.
